// File: rtl/sw_out_scheduler_pkg.sv
// Shared definitions for the per-output packet scheduler.
//   N_PORTS / TARG_W  : port count and width of one packed target/select field
//   CREDITS_DEF       : default downstream buffer depth per output
//   ST_IDLE/ST_LOCKED : per-output FSM encoding
//   targ_get/sel_put  : unpack one target field, pack one crossbar select field
package sw_out_scheduler_pkg;

  localparam int unsigned N_PORTS     = 7;
  localparam int unsigned TARG_W      = 3;
  localparam int unsigned CREDITS_DEF = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic logic [TARG_W-1:0] targ_get(
    input logic [N_PORTS*TARG_W-1:0] pack,
    input int unsigned               k
  );
    return pack[k*TARG_W +: TARG_W];
  endfunction

  function automatic logic [N_PORTS*TARG_W-1:0] sel_put(
    input logic [N_PORTS*TARG_W-1:0] pack,
    input int unsigned               o,
    input logic [TARG_W-1:0]         val
  );
    logic [N_PORTS*TARG_W-1:0] r;
    r = pack;
    r[o*TARG_W +: TARG_W] = val;
    return r;
  endfunction

  // Round-robin pointer advance, wrapping 6 -> 0.
  function automatic logic [TARG_W-1:0] ptr_inc(input logic [TARG_W-1:0] p);
    return (p == TARG_W'(N_PORTS - 1)) ? '0 : p + TARG_W'(1);
  endfunction

endpackage

// File: rtl/sw_out_scheduler_rr_arb7.sv
// 7-way round-robin priority picker.
//   req_i : request vector, bit k = input k
//   ptr_i : highest-priority index (0-6)
//   gnt_o : one-hot grant
//   idx_o : index of the granted request
//   any_o : at least one request present
module rr_arb7 (
  input  logic [6:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [6:0] gnt_o,
  output logic [2:0] idx_o,
  output logic       any_o
);

  // Candidate index ptr+off modulo 7.
  function automatic logic [2:0] wrap_add(input logic [2:0] p, input int unsigned off);
    logic [3:0] s;
    s = {1'b0, p} + 4'(off);
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0];
  endfunction

  always_comb begin
    logic [2:0] cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < 7; off++) begin
      cand = wrap_add(ptr_i, off);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_out_scheduler.sv
// Per-output packet scheduler for the 7-port router crossbar.
//   clk, rst       : clock, synchronous active-low reset
//   targ_pack      : 3-bit target output per input (1-7, 0 = none)
//   flit_vld       : input k has a flit at its buffer head
//   flit_tail      : that flit is the packet tail
//   credit_in      : per-output pulse, downstream freed one slot
//   pop_ctrl       : input k granted this cycle (pops at this edge)
//   xbar_sel_pack  : per output, granted input index + 1 (0 = idle)
//   out_locked     : output held by an in-progress multi-flit packet
//   credit_err     : sticky credit overflow flag
module sw_out_scheduler #(
  parameter int unsigned N_PORTS = 7,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CW      = 3   // 2**CW must exceed CREDITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_PORTS*3-1:0]   targ_pack,
  input  logic [N_PORTS-1:0]     flit_vld,
  input  logic [N_PORTS-1:0]     flit_tail,
  input  logic [N_PORTS-1:0]     credit_in,
  output logic [N_PORTS-1:0]     pop_ctrl,
  output logic [N_PORTS*3-1:0]   xbar_sel_pack,
  output logic [N_PORTS-1:0]     out_locked,
  output logic                   credit_err
);

  import sw_out_scheduler_pkg::*;

  logic [N_PORTS-1:0] state_q, state_d;
  logic [2:0]         rr_ptr_q [N_PORTS];
  logic [2:0]         rr_ptr_d [N_PORTS];
  logic [2:0]         owner_q  [N_PORTS];
  logic [2:0]         owner_d  [N_PORTS];
  logic [CW-1:0]      cnt_q    [N_PORTS];
  logic [CW-1:0]      cnt_d    [N_PORTS];
  logic               err_q, err_d;

  logic [N_PORTS-1:0] req    [N_PORTS];
  logic [N_PORTS-1:0] rr_gnt [N_PORTS];
  logic [2:0]         rr_idx [N_PORTS];
  logic [N_PORTS-1:0] rr_any;

  logic [N_PORTS-1:0]   pop_c;
  logic [N_PORTS*3-1:0] sel_c;

  // Request matrix: req[o][k] = input k wants output o.
  always_comb begin
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      req[o] = '0;
      for (int unsigned k = 0; k < N_PORTS; k++)
        req[o][k] = flit_vld[k] && (targ_get(targ_pack, k) == 3'(o + 1));
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
    rr_arb7 u_arb (
      .req_i (req[o]),
      .ptr_i (rr_ptr_q[o]),
      .gnt_o (rr_gnt[o]),
      .idx_o (rr_idx[o]),
      .any_o (rr_any[o])
    );
  end

  always_comb begin
    logic       granted;
    logic [2:0] win;
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pop_c    = '0;
    sel_c    = '0;
    granted  = 1'b0;
    win      = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      granted = 1'b0;
      win     = '0;
      if (cnt_q[o] != '0) begin
        if (state_q[o] == ST_LOCKED) begin
          // Only the owner may continue; a missing owner flit is a bubble.
          if (req[o][owner_q[o]]) begin
            granted            = 1'b1;
            win                = owner_q[o];
            pop_c[owner_q[o]]  = 1'b1;
          end
        end else if (rr_any[o]) begin
          granted = 1'b1;
          win     = rr_idx[o];
          pop_c   = pop_c | rr_gnt[o];
        end
      end

      if (granted) begin
        sel_c = sel_put(sel_c, o, win + 3'd1);
        if (flit_tail[win]) begin
          state_d[o]  = ST_IDLE;
          rr_ptr_d[o] = ptr_inc(win);
        end else begin
          state_d[o]  = ST_LOCKED;
          owner_d[o]  = win;
        end
      end

      if (granted && !credit_in[o]) begin
        cnt_d[o] = cnt_q[o] - CW'(1);
      end else if (!granted && credit_in[o]) begin
        if (cnt_q[o] == CW'(CREDITS)) err_d = 1'b1;
        else                          cnt_d[o] = cnt_q[o] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        rr_ptr_q[o] <= '0;
        owner_q[o]  <= '0;
        cnt_q[o]    <= CW'(CREDITS);
      end
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pop_ctrl      = rst ? pop_c   : '0;
  assign xbar_sel_pack = rst ? sel_c   : '0;
  assign out_locked    = rst ? state_q : '0;
  assign credit_err    = err_q;

endmodule

// File: tb/tb_sw_out_scheduler.sv
// Bench for sw_out_scheduler: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_sw_out_scheduler;

  localparam int NP   = 7;
  localparam int CRED = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [20:0]   targ_pack;
  logic [6:0]    flit_vld, flit_tail, credit_in;
  logic [6:0]    pop_ctrl, out_locked;
  logic [20:0]   xbar_sel_pack;
  logic          credit_err;

  always #5 clk = ~clk;

  sw_out_scheduler #(.N_PORTS(7), .CREDITS(4), .CW(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .targ_pack     (targ_pack),
    .flit_vld      (flit_vld),
    .flit_tail     (flit_tail),
    .credit_in     (credit_in),
    .pop_ctrl      (pop_ctrl),
    .xbar_sel_pack (xbar_sel_pack),
    .out_locked    (out_locked),
    .credit_err    (credit_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit run_chk = 1'b0;

  // Model: per output credits left, lock holder and round-robin start point.
  int m_cred  [NP];
  bit m_lock  [NP];
  int m_owner [NP];
  int m_ptr   [NP];
  bit m_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int targ_of(input int k);
    return int'(targ_pack[3*k +: 3]);
  endfunction

  function automatic int sel_of(input int o);
    return int'(xbar_sel_pack[3*o +: 3]);
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_cred[o] = CRED; m_lock[o] = 1'b0; m_owner[o] = 0; m_ptr[o] = 0;
    end
    m_err = 1'b0;
  endtask

  initial model_reset();

  // Compare process: inputs are stable from posedge+1 until the next posedge,
  // so the model predicts this cycle's outputs and then steps to the next edge.
  always @(negedge clk) begin
    int         win [NP];
    int         k;
    logic [6:0] e_pop, e_lock;
    logic [20:0] e_sel;
    if (run_chk) begin
      e_pop = '0; e_lock = '0; e_sel = '0;
      for (int o = 0; o < NP; o++) begin
        win[o] = -1;
        e_lock[o] = m_lock[o];
        if (rst && m_cred[o] > 0) begin
          if (m_lock[o]) begin
            if (flit_vld[m_owner[o]] && targ_of(m_owner[o]) == o + 1) win[o] = m_owner[o];
          end else begin
            for (int i = 0; i < NP; i++) begin
              k = (m_ptr[o] + i) % NP;
              if (win[o] < 0 && flit_vld[k] && targ_of(k) == o + 1) win[o] = k;
            end
          end
        end
        if (win[o] >= 0) begin
          e_pop[win[o]] = 1'b1;
          e_sel[3*o +: 3] = 3'(win[o] + 1);
        end
      end
      if (!rst) e_lock = '0;
      check("pop_ctrl", 32'(pop_ctrl), 32'(e_pop));
      check("xbar_sel_pack", 32'(xbar_sel_pack), 32'(e_sel));
      check("out_locked", 32'(out_locked), 32'(e_lock));
      check("credit_err", 32'(credit_err), 32'(m_err));
      if (!rst) model_reset();
      else begin
        for (int o = 0; o < NP; o++) begin
          if (win[o] >= 0) begin
            if (flit_tail[win[o]]) begin m_lock[o] = 1'b0; m_ptr[o] = (win[o] + 1) % NP; end
            else begin m_lock[o] = 1'b1; m_owner[o] = win[o]; end
          end
          if (win[o] >= 0 && !credit_in[o]) m_cred[o]--;
          else if (win[o] < 0 && credit_in[o]) begin
            if (m_cred[o] == CRED) m_err = 1'b1;
            else m_cred[o]++;
          end
        end
      end
    end
  end

  task automatic clr_in();
    targ_pack = '0; flit_vld = '0; flit_tail = '0; credit_in = '0;
  endtask

  task automatic set_in(input int k, input int t, input bit v, input bit tl);
    targ_pack[3*k +: 3] = 3'(t);
    flit_vld[k]  = v;
    flit_tail[k] = tl;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    #3;
  endtask

  initial begin
    int grants;
    rst = 1'b0;
    clr_in();
    nxt();
    run_chk = 1'b1;
    smp();
    check("rst_pop", 32'(pop_ctrl), 32'h0);
    check("rst_err", 32'(credit_err), 32'h0);
    nxt();
    rst = 1'b1;

    // Round-robin among three single-flit requesters on output 3.
    set_in(0, 3, 1, 1); set_in(2, 3, 1, 1); set_in(5, 3, 1, 1);
    smp(); check("rr_pop_a", 32'(pop_ctrl), 32'h01); check("rr_sel_a", 32'(sel_of(2)), 32'd1);
    nxt(); set_in(0, 0, 0, 0);
    smp(); check("rr_pop_b", 32'(pop_ctrl), 32'h04); check("rr_sel_b", 32'(sel_of(2)), 32'd3);
    nxt(); set_in(2, 0, 0, 0);
    smp(); check("rr_pop_c", 32'(pop_ctrl), 32'h20); check("rr_sel_c", 32'(sel_of(2)), 32'd6);
    nxt(); clr_in();

    // 3-flit packet from input 1 to output 2, input 4 waits.
    set_in(1, 2, 1, 0); set_in(4, 2, 1, 1);
    smp(); check("pkt_f1", 32'(pop_ctrl), 32'h02);
    nxt();
    smp(); check("pkt_f2", 32'(pop_ctrl), 32'h02); check("pkt_lock2", 32'(out_locked[1]), 32'd1);
    nxt(); flit_tail[1] = 1'b1;
    smp(); check("pkt_f3", 32'(pop_ctrl), 32'h02); check("pkt_lock3", 32'(out_locked[1]), 32'd1);
    nxt(); set_in(1, 0, 0, 0);
    smp(); check("pkt_other", 32'(pop_ctrl), 32'h10); check("pkt_sel", 32'(sel_of(1)), 32'd5);
    nxt(); clr_in();
    credit_in = 7'h02;
    repeat (4) nxt();
    credit_in = '0;

    // Owner bubble: valid drops for two cycles mid-packet.
    set_in(1, 2, 1, 0); set_in(4, 2, 1, 1);
    smp(); check("bub_head", 32'(pop_ctrl), 32'h02);
    nxt(); flit_vld[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      smp(); check("bub_none", 32'(pop_ctrl), 32'h0); check("bub_lock", 32'(out_locked[1]), 32'd1);
      nxt();
    end
    flit_vld[1] = 1'b1; flit_tail[1] = 1'b1;
    smp(); check("bub_resume", 32'(pop_ctrl), 32'h02);
    nxt(); set_in(1, 0, 0, 0);
    smp(); check("bub_other", 32'(pop_ctrl), 32'h10);
    nxt(); clr_in();

    // Credit exhaustion on output 7.
    for (int k = 0; k < 6; k++) set_in(k, 7, 1, 1);
    grants = 0;
    repeat (6) begin
      smp();
      if (pop_ctrl != '0) grants++;
      for (int k = 0; k < NP; k++) if (pop_ctrl[k]) set_in(k, 0, 0, 0);
      nxt();
    end
    check("cred_stall_grants", 32'(grants), 32'd4);
    credit_in = 7'h40;
    smp(); check("cred_zero_nogrant", 32'(pop_ctrl), 32'h0);
    nxt(); credit_in = '0;
    grants = 0;
    repeat (3) begin
      smp();
      if (pop_ctrl != '0) grants++;
      for (int k = 0; k < NP; k++) if (pop_ctrl[k]) set_in(k, 0, 0, 0);
      nxt();
    end
    check("cred_one_more", 32'(grants), 32'd1);
    clr_in();

    // Simultaneous grant and credit at count 1, then overflow.
    credit_in = 7'h40;
    nxt();
    set_in(0, 7, 1, 1);
    smp(); check("cred_both", 32'(pop_ctrl), 32'h01);
    nxt(); credit_in = '0; set_in(0, 0, 0, 0); set_in(1, 7, 1, 1);
    smp(); check("cred_held", 32'(pop_ctrl), 32'h02);
    nxt(); clr_in();
    credit_in = 7'h40;
    repeat (4) nxt();
    smp(); check("err_clear", 32'(credit_err), 32'd0);
    nxt(); credit_in = '0;
    smp(); check("err_set", 32'(credit_err), 32'd1);
    repeat (3) nxt();
    smp(); check("err_sticky", 32'(credit_err), 32'd1);
    nxt();

    // Reset mid-lock.
    set_in(3, 1, 1, 0);
    smp(); check("rl_grant", 32'(pop_ctrl), 32'h08);
    nxt();
    smp(); check("rl_locked", 32'(out_locked[0]), 32'd1);
    nxt(); rst = 1'b0;
    smp(); check("rl_pop0", 32'(pop_ctrl), 32'h0); check("rl_lock0", 32'(out_locked), 32'h0);
    check("rl_sel0", 32'(xbar_sel_pack), 32'h0);
    nxt(); rst = 1'b1;
    smp(); check("rl_unlocked", 32'(out_locked), 32'h0); check("rl_regrant", 32'(pop_ctrl), 32'h08);
    check("rl_err_cleared", 32'(credit_err), 32'd0);
    nxt(); clr_in();

    // Randomized traffic with occasional resets and between-edge rst glitches.
    repeat (3000) begin
      for (int k = 0; k < NP; k++) begin
        targ_pack[3*k +: 3] = 3'($urandom_range(0, 7));
        flit_vld[k]  = ($urandom_range(0, 3) != 0);
        flit_tail[k] = ($urandom_range(0, 2) == 0);
        credit_in[k] = ($urandom_range(0, 4) == 0);
      end
      rst = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = ~rst;
        #1 rst = ~rst;
      end
      nxt();
    end

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
